// File: rtl/microcode_ctrl.sv
// microcode_ctrl: microcoded control unit for an N-bit datapath.
// It fetches a 16-bit instruction into IR, then steps a micro-PC (upc 0..4)
// and emits one control word per cycle. Control outputs are a combinational
// decode of (upc, IR, flags). Register 7 is the program counter.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   instr, instr_valid       instruction word and its valid strobe (sampled in FETCH)
//   step                     single-step gate (present only with CTRL_SINGLE_STEP_EN)
//   z_flag, n_flag, o_flag   datapath ALU flags
//   instr_req                high while in FETCH (and not in reset)
//   ie, write, reada, readb  datapath / register-file enables
//   en, oe                   ALU+flag enable, datapath dout enable
//   bypassa, bypassb         offset replaces operand A / B
//   mov_sel                  dout sources operand B
//   op                       ALU op (000 ADD .. 110 PASS A, 111 INC A)
//   waddr, ra, rb            register addresses
//   offset                   immediate to datapath
//   mem_we                   data memory write strobe
//   upc                      current micro-PC (debug)
//
// Optional feature macro: CTRL_SINGLE_STEP_EN (adds the step input).
module microcode_ctrl #(
  parameter int M = 3,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  instr,
  input  logic         instr_valid,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic         step,
`endif
  input  logic         z_flag,
  input  logic         n_flag,
  input  logic         o_flag,
  output logic         instr_req,
  output logic         ie,
  output logic         write,
  output logic         reada,
  output logic         readb,
  output logic         en,
  output logic         oe,
  output logic         bypassa,
  output logic         bypassb,
  output logic         mov_sel,
  output logic [2:0]   op,
  output logic [M-1:0] waddr,
  output logic [M-1:0] ra,
  output logic [M-1:0] rb,
  output logic [N-1:0] offset,
  output logic         mem_we,
  output logic [2:0]   upc
);

  localparam logic [2:0] UPC_FETCH = 3'd0;
  localparam logic [2:0] UPC_1     = 3'd1;
  localparam logic [2:0] UPC_2     = 3'd2;
  localparam logic [2:0] UPC_3     = 3'd3;
  localparam logic [2:0] UPC_4     = 3'd4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_INC  = 3'b111;

  localparam logic [M-1:0] PC_REG = '1;

  logic [15:0]  ir;
  logic [2:0]   flags;      // {Z, N, O}
  logic [2:0]   upc_nxt;
  logic         pcinc;
  logic         br_taken;
  logic         br_cond;
  logic         fetch_go;
  logic [3:0]   opc;
  logic [M-1:0] rd, rs1, rs2;
  logic [N-1:0] imm_ext;

  assign opc = ir[15:12];
  assign rd  = M'(ir[11:9]);
  assign rs1 = M'(ir[8:6]);
  assign rs2 = M'(ir[5:3]);

  generate
    if (N > 9) begin : g_sext
      assign imm_ext = {{(N-9){ir[8]}}, ir[8:0]};
    end else begin : g_trunc
      assign imm_ext = ir[N-1:0];
    end
  endgenerate

`ifdef CTRL_SINGLE_STEP_EN
  assign fetch_go = instr_valid & step;
`else
  assign fetch_go = instr_valid;
`endif

  always_comb begin
    case (opc[1:0])
      2'b00:   br_cond = flags[2];
      2'b01:   br_cond = flags[1];
      2'b10:   br_cond = flags[0];
      default: br_cond = 1'b1;
    endcase
  end

  always_comb begin
    instr_req = 1'b0;
    ie        = 1'b0;
    write     = 1'b0;
    reada     = 1'b0;
    readb     = 1'b0;
    en        = 1'b0;
    oe        = 1'b0;
    bypassa   = 1'b0;
    bypassb   = 1'b0;
    mov_sel   = 1'b0;
    op        = OP_ADD;
    waddr     = '0;
    ra        = '0;
    rb        = '0;
    offset    = '0;
    mem_we    = 1'b0;
    upc_nxt   = upc + 3'd1;
    pcinc     = 1'b0;
    br_taken  = 1'b0;

    if (upc == UPC_FETCH) begin
      instr_req = ~rst;
      upc_nxt   = UPC_FETCH;
    end else begin
      case (opc)
        4'b0000, 4'b0001, 4'b0010, 4'b0011,
        4'b0100, 4'b0101, 4'b0110: begin
          if (upc == UPC_1) begin
            reada = 1'b1; readb = 1'b1; ra = rs1; rb = rs2;
          end else if (upc == UPC_2) begin
            reada = 1'b1; readb = 1'b1; en = 1'b1; write = 1'b1;
            waddr = rd;
            op    = (opc == 4'b0110) ? OP_PASS : opc[2:0];
          end else begin
            pcinc = 1'b1;
          end
        end
        4'b1000: begin  // LD
          if (upc == UPC_1) begin
            reada = 1'b1; ra = rs1; op = OP_PASS; en = 1'b1; oe = 1'b1;
          end else if (upc == UPC_2) begin
            ie = 1'b1; write = 1'b1; waddr = rd;
          end else begin
            pcinc = 1'b1;
          end
        end
        4'b1001: begin  // ST
          if (upc == UPC_1) begin
            reada = 1'b1; readb = 1'b1; ra = rs1; rb = rs2;
          end else if (upc == UPC_2) begin
            reada = 1'b1; readb = 1'b1; op = OP_PASS; en = 1'b1; oe = 1'b1;
          end else if (upc == UPC_3) begin
            reada = 1'b1; readb = 1'b1; mov_sel = 1'b1; oe = 1'b1; mem_we = 1'b1;
          end else begin
            pcinc = 1'b1;
          end
        end
        4'b1010: begin  // LDI
          if (upc == UPC_1) begin
            bypassa = 1'b1; op = OP_PASS; en = 1'b1; write = 1'b1;
            waddr   = rd;   offset = imm_ext;
          end else begin
            pcinc = 1'b1;
          end
        end
        4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
          if (upc == UPC_1 && br_cond) begin
            reada  = 1'b1; ra = PC_REG; bypassb = 1'b1; offset = imm_ext;
            op     = OP_ADD; en = 1'b1; write = 1'b1; waddr = PC_REG; oe = 1'b1;
            br_taken = 1'b1;
            upc_nxt  = UPC_FETCH;
          end else begin
            pcinc = 1'b1;
          end
        end
        default: pcinc = 1'b1;  // NOP encodings
      endcase
    end

    // Shared PC increment; also the landing step for any out-of-range upc.
    if (pcinc) begin
      reada   = 1'b1; ra = PC_REG; op = OP_INC; en = 1'b1;
      write   = 1'b1; waddr = PC_REG; oe = 1'b1;
      upc_nxt = UPC_FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upc   <= UPC_FETCH;
      ir    <= '0;
      flags <= '0;
    end else begin
      if (upc == UPC_FETCH) begin
        if (fetch_go) begin
          ir  <= instr;
          upc <= UPC_1;
        end
      end else if (upc_nxt > UPC_4) begin
        upc <= UPC_FETCH;
      end else begin
        upc <= upc_nxt;
      end
      // Taken branches use op=ADD on the PC; they must not disturb flags.
      if (en && op != OP_INC && !br_taken)
        flags <= {z_flag, n_flag, o_flag};
    end
  end

endmodule

// File: tb/tb_microcode_ctrl.sv
// tb_microcode_ctrl: directed bench for microcode_ctrl. Expected control words
// are queued as each instruction is issued and popped one per cycle.
module tb_microcode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        z_flag, n_flag, o_flag;
`ifdef CTRL_SINGLE_STEP_EN
  logic        step;
`endif
  logic        instr_req, ie, write, reada, readb, en, oe;
  logic        bypassa, bypassb, mov_sel, mem_we;
  logic [2:0]  op, waddr, ra, rb, upc;
  logic [7:0]  offset;

  always #5 clk = ~clk;

  microcode_ctrl #(.M(3), .N(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .z_flag(z_flag), .n_flag(n_flag), .o_flag(o_flag),
    .instr_req(instr_req), .ie(ie), .write(write), .reada(reada), .readb(readb),
    .en(en), .oe(oe), .bypassa(bypassa), .bypassb(bypassb), .mov_sel(mov_sel),
    .op(op), .waddr(waddr), .ra(ra), .rb(rb), .offset(offset),
    .mem_we(mem_we), .upc(upc)
  );

  // {instr_req, ie, write, reada, readb, en, oe, bypassa, bypassb, mov_sel}
  localparam logic [9:0] IRQ = 10'h200, IE = 10'h100, WR = 10'h080, RA = 10'h040;
  localparam logic [9:0] RB  = 10'h020, EN = 10'h010, OE = 10'h008, BA = 10'h004;
  localparam logic [9:0] BB  = 10'h002, MS = 10'h001;

  logic [33:0] obs;
  assign obs = {instr_req, ie, write, reada, readb, en, oe, bypassa, bypassb,
                mov_sel, op, waddr, ra, rb, offset, mem_we, upc};

  logic [33:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  function automatic logic [33:0] W(input logic [9:0] b, input logic [2:0] o,
                                    input logic [2:0] wa, input logic [2:0] a,
                                    input logic [2:0] bb, input logic [7:0] off,
                                    input logic we, input logic [2:0] u);
    return {b, o, wa, a, bb, off, we, u};
  endfunction

  function automatic logic [33:0] F();
    return W(IRQ, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 3'd0);
  endfunction

  function automatic logic [33:0] P(input logic [2:0] u);
    return W(RA | WR | EN | OE, 3'b111, 3'd7, 3'd7, 3'd0, 8'h00, 1'b0, u);
  endfunction

  function automatic logic [33:0] T(input logic [7:0] off);
    return W(RA | BB | EN | WR | OE, 3'b000, 3'd7, 3'd7, 3'd0, off, 1'b0, 3'd1);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag);
    logic [33:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    total++;
    assert (obs === e) passed++;
    else $error("FAIL %s upc=%0d observed=%h expected=%h", tag, upc, obs, e);
  endtask

  // Issue iw and drain cnt expected words; bf drives {z,n,o} on all but the
  // final step, tf on the final step.
  task automatic run(input string tag, input logic [15:0] iw, input int cnt,
                     input logic [2:0] bf, input logic [2:0] tf);
    instr = iw;
    instr_valid = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      {z_flag, n_flag, o_flag} = (i == cnt - 1) ? tf : bf;
      chk(tag);
      cyc();
      instr_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0;
    {z_flag, n_flag, o_flag} = 3'b000;
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b1;
`endif
    #1;
    exp_q.push_back('0); chk("reset_state");
    cyc();
    exp_q.push_back('0); chk("reset_held");
    rst = 1'b0; #1;
    exp_q.push_back(F()); chk("first_fetch");

    // Idle FETCH with no valid instruction
    for (int i = 0; i < 3; i++) begin
      cyc();
      exp_q.push_back(F()); chk("idle_fetch");
    end

    // ADD rd=3 rs1=0 rs2=1
    exp_q.push_back(F());
    exp_q.push_back(W(RA | RB, 3'b000, 3'd0, 3'd0, 3'd1, 8'h00, 1'b0, 3'd1));
    exp_q.push_back(W(RA | RB | EN | WR, 3'b000, 3'd3, 3'd0, 3'd0, 8'h00, 1'b0, 3'd2));
    exp_q.push_back(P(3'd3));
    run("add", 16'h0608, 4, 3'b000, 3'b000);

    // LDI rd=0 imm=20
    exp_q.push_back(F());
    exp_q.push_back(W(BA | EN | WR, 3'b110, 3'd0, 3'd0, 3'd0, 8'h14, 1'b0, 3'd1));
    exp_q.push_back(P(3'd2));
    run("ldi", 16'hA014, 3, 3'b000, 3'b000);

    // ST rs1=2 rs2=5
    exp_q.push_back(F());
    exp_q.push_back(W(RA | RB, 3'b000, 3'd0, 3'd2, 3'd5, 8'h00, 1'b0, 3'd1));
    exp_q.push_back(W(RA | RB | EN | OE, 3'b110, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 3'd2));
    exp_q.push_back(W(RA | RB | MS | OE, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 1'b1, 3'd3));
    exp_q.push_back(P(3'd4));
    run("st", 16'h90A8, 5, 3'b000, 3'b000);

    // LD rd=1 rs1=4; N flag captured at upc1 -> flags {0,1,0}
    exp_q.push_back(F());
    exp_q.push_back(W(RA | EN | OE, 3'b110, 3'd0, 3'd4, 3'd0, 8'h00, 1'b0, 3'd1));
    exp_q.push_back(W(IE | WR, 3'b000, 3'd1, 3'd0, 3'd0, 8'h00, 1'b0, 3'd2));
    exp_q.push_back(P(3'd3));
    run("ld", 16'h8300, 4, 3'b010, 3'b000);

    // BRN +5 taken twice: the first taken branch must not reload flags
    exp_q.push_back(F()); exp_q.push_back(T(8'h05));
    run("brn_taken", 16'hD005, 2, 3'b000, 3'b000);
    exp_q.push_back(F()); exp_q.push_back(T(8'h05));
    run("brn_taken_again", 16'hD005, 2, 3'b000, 3'b000);

    // BRO not taken; not-taken PCINC must not load the driven 111
    exp_q.push_back(F()); exp_q.push_back(P(3'd1));
    run("bro_not_taken", 16'hE002, 2, 3'b111, 3'b111);
    exp_q.push_back(F()); exp_q.push_back(T(8'h05));
    run("brn_after_bro", 16'hD005, 2, 3'b000, 3'b000);

    // SUB producing zero; PCINC sees Z=0 but must not clobber
    exp_q.push_back(F());
    exp_q.push_back(W(RA | RB, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 3'd1));
    exp_q.push_back(W(RA | RB | EN | WR, 3'b001, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 3'd2));
    exp_q.push_back(P(3'd3));
    run("sub_zero", 16'h1000, 4, 3'b100, 3'b000);
    exp_q.push_back(F()); exp_q.push_back(T(8'hFD));
    run("brz_taken", 16'hC1FD, 2, 3'b000, 3'b000);

    // ADD nonzero; PCINC drives Z=1 which must be ignored
    exp_q.push_back(F());
    exp_q.push_back(W(RA | RB, 3'b000, 3'd0, 3'd0, 3'd1, 8'h00, 1'b0, 3'd1));
    exp_q.push_back(W(RA | RB | EN | WR, 3'b000, 3'd3, 3'd0, 3'd0, 8'h00, 1'b0, 3'd2));
    exp_q.push_back(P(3'd3));
    run("add_nonzero", 16'h0608, 4, 3'b000, 3'b100);
    exp_q.push_back(F()); exp_q.push_back(P(3'd1));
    run("brz_not_taken", 16'hC1FD, 2, 3'b000, 3'b000);

    // BRA -1 always taken
    exp_q.push_back(F()); exp_q.push_back(T(8'hFF));
    run("bra", 16'hF1FF, 2, 3'b000, 3'b000);

    // Both NOP encodings
    exp_q.push_back(F()); exp_q.push_back(P(3'd1));
    run("nop7", 16'h7000, 2, 3'b000, 3'b000);
    exp_q.push_back(F()); exp_q.push_back(P(3'd1));
    run("nopb", 16'hB000, 2, 3'b000, 3'b000);

    // MOV rd=1 rs1=0 rs2=1 uses PASS A
    exp_q.push_back(F());
    exp_q.push_back(W(RA | RB, 3'b000, 3'd0, 3'd0, 3'd1, 8'h00, 1'b0, 3'd1));
    exp_q.push_back(W(RA | RB | EN | WR, 3'b110, 3'd1, 3'd0, 3'd0, 8'h00, 1'b0, 3'd2));
    exp_q.push_back(P(3'd3));
    run("mov", 16'h6208, 4, 3'b000, 3'b000);

`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b0; instr = 16'h7000; instr_valid = 1'b1;
    exp_q.push_back(F()); chk("step_hold");
    cyc();
    exp_q.push_back(F()); chk("step_hold_next");
    step = 1'b1;
    exp_q.push_back(F()); exp_q.push_back(P(3'd1));
    run("step_go", 16'h7000, 2, 3'b000, 3'b000);
`endif

    // Reset in the middle of ST, at upc3
    exp_q.push_back(F());
    exp_q.push_back(W(RA | RB, 3'b000, 3'd0, 3'd2, 3'd5, 8'h00, 1'b0, 3'd1));
    exp_q.push_back(W(RA | RB | EN | OE, 3'b110, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 3'd2));
    run("st_pre_reset", 16'h90A8, 3, 3'b000, 3'b000);
    rst = 1'b1; #1;
    exp_q.push_back('0); chk("reset_mid_st");
    cyc();
    exp_q.push_back('0); chk("reset_mid_st_held");
    rst = 1'b0; #1;
    exp_q.push_back(F()); chk("fetch_after_reset");
    for (int i = 0; i < 2; i++) begin
      cyc();
      exp_q.push_back(F()); chk("idle_after_reset");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
